// File: rtl/regfile_loader_if.sv
// Preload stream from the test harness into regfile_loader: one (index, value) word per handshake.
interface regfile_loader_if #(
  parameter int unsigned IDX_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_reg;
  logic [31:0]      in_data;
  logic             in_last;

  modport master (
    output in_valid,
    output in_reg,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_reg,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/regfile_loader.sv
// Preload-and-run sequencer: writes preload words into the regfile with the processor held in
// reset, releases the processor for a programmed number of cycles, then freezes it.
module regfile_loader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CYC_W    = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CYC_W-1:0]            num_cycles,
  regfile_loader_if.slave             pre,
  output logic                        wr_en,
  output logic [$clog2(NUM_REGS)-1:0] wr_reg,
  output logic [31:0]                 wr_data,
  output logic                        loader_active,
  output logic                        proc_reset,
  output logic [CYC_W-1:0]            run_count,
  output logic                        done,
  output logic                        error
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRelease,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  ncyc_q, ncyc_d;
  logic [CYC_W-1:0]  run_count_q, run_count_d;
  logic              error_q, error_d;
  logic              wr_en_q, wr_en_d;
  logic [IdxW-1:0]   wr_reg_q, wr_reg_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              handshake;

  assign handshake = pre.in_valid && (state_q == StLoad);

  always_comb begin
    state_d     = state_q;
    ncyc_d      = ncyc_q;
    run_count_d = run_count_q;
    error_d     = error_q;
    wr_en_d     = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StLoad;
          ncyc_d      = num_cycles;
          run_count_d = '0;
          error_d     = 1'b0;
        end
      end
      StLoad: begin
        if (handshake) begin
          // r0 is hardwired: flag the attempt instead of issuing the write.
          if (pre.in_reg == '0) begin
            error_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_reg_d  = pre.in_reg;
            wr_data_d = pre.in_data;
          end
          if (pre.in_last) begin
            state_d = StRelease;
          end
        end
      end
      StRelease: begin
        state_d = (ncyc_q != '0) ? StRun : StDone;
      end
      StRun: begin
        run_count_d = run_count_q + 1'b1;
        if (run_count_q == ncyc_q - 1'b1) begin
          state_d = StDone;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ncyc_q      <= '0;
      run_count_q <= '0;
      error_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      ncyc_q      <= ncyc_d;
      run_count_q <= run_count_d;
      error_q     <= error_d;
      wr_en_q     <= wr_en_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // All status outputs decode from registered state, so async reset reaches them immediately.
  assign pre.in_ready    = (state_q == StLoad);
  assign loader_active   = (state_q == StLoad) || (state_q == StRelease);
  assign proc_reset      = (state_q != StRun);
  assign done            = (state_q == StDone);
  assign run_count       = run_count_q;
  assign error           = error_q;
  assign wr_en           = wr_en_q;
  assign wr_reg          = wr_reg_q;
  assign wr_data         = wr_data_q;

endmodule

// File: tb/tb_regfile_loader.sv
// Scoreboard bench for regfile_loader: expected regfile writes are queued as words are driven.
module tb_regfile_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  num_cycles = '0;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        loader_active;
  logic        proc_reset;
  logic [9:0]  run_count;
  logic        done;
  logic        error;

  regfile_loader_if #(.IDX_W(5)) pre ();

  regfile_loader #(
    .NUM_REGS(32),
    .CYC_W   (10)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .num_cycles   (num_cycles),
    .pre          (pre),
    .wr_en        (wr_en),
    .wr_reg       (wr_reg),
    .wr_data      (wr_data),
    .loader_active(loader_active),
    .proc_reset   (proc_reset),
    .run_count    (run_count),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          pr_low  = 0;
  logic [36:0] sb_q[$];
  logic [36:0] sb_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: count processor-run cycles and score every write pulse.
  always @(negedge clock) begin
    if (reset) begin
      if (!proc_reset) pr_low++;
      if (wr_en) begin
        if (sb_q.size() == 0) begin
          check("wr_unexpected", 64'(wr_en), 64'd0);
        end else begin
          sb_exp = sb_q.pop_front();
          check("wr_port", {27'd0, wr_reg, wr_data}, {27'd0, sb_exp});
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals();
    check("rst_proc_reset", 64'(proc_reset), 64'd1);
    check("rst_in_ready", 64'(pre.in_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_reg", 64'(wr_reg), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_active", 64'(loader_active), 64'd0);
    check("rst_run_count", 64'(run_count), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
  endtask

  task automatic start_seq(input int n);
    pr_low     = 0;
    start      = 1'b1;
    num_cycles = 10'(n);
    step();
    start = 1'b0;
    check("start_ready", 64'(pre.in_ready), 64'd1);
    check("start_active", 64'(loader_active), 64'd1);
  endtask

  task automatic send(input logic [4:0] r, input logic [31:0] d, input logic last,
                      input int gap);
    int k;
    repeat (gap) step();
    pre.in_valid = 1'b1;
    pre.in_reg   = r;
    pre.in_data  = d;
    pre.in_last  = last;
    if (r != 5'd0) sb_q.push_back({r, d});
    k = 0;
    while (!pre.in_ready && k < 20) begin
      step();
      k++;
    end
    if (!pre.in_ready) check("ready_timeout", 64'(pre.in_ready), 64'd1);
    step();
    pre.in_valid = 1'b0;
    pre.in_last  = 1'b0;
  endtask

  // Called right after the in_last handshake, i.e. while in RELEASE.
  task automatic finish_run(input int n);
    check("rel_active", 64'(loader_active), 64'd1);
    check("rel_ready", 64'(pre.in_ready), 64'd0);
    step();
    check("active_drop", 64'(loader_active), 64'd0);
    for (int i = 0; i < 1100 && !done; i++) step();
    check("done", 64'(done), 64'd1);
    check("pr_low_cycles", 64'(pr_low), 64'(n));
    check("run_count", 64'(run_count), 64'(n));
    check("sb_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    pre.in_valid = 1'b0;
    pre.in_reg   = '0;
    pre.in_data  = '0;
    pre.in_last  = 1'b0;
    #3;
    chk_reset_vals();
    #9 reset = 1'b1;
    step();
    check("idle_ready", 64'(pre.in_ready), 64'd0);
    check("idle_proc_reset", 64'(proc_reset), 64'd1);

    // Basic load: r1=5, r2=-1, three run cycles.
    start_seq(3);
    send(5'd1, 32'd5, 1'b0, 0);
    send(5'd2, 32'hFFFF_FFFF, 1'b1, 0);
    finish_run(3);

    // Restart from DONE.
    start_seq(4);
    send(5'd5, 32'd1, 1'b1, 0);
    finish_run(4);

    // Gapped valid.
    start_seq(2);
    send(5'd3, 32'd7, 1'b0, 2);
    send(5'd4, 32'd9, 1'b1, 2);
    finish_run(2);

    // r0 write attempt: no write pulse, sticky error.
    start_seq(2);
    send(5'd0, 32'h1234, 1'b0, 0);
    check("error_set", 64'(error), 64'd1);
    send(5'd6, 32'hAB, 1'b1, 0);
    finish_run(2);
    check("error_sticky", 64'(error), 64'd1);
    start_seq(1);
    check("error_clear", 64'(error), 64'd0);
    send(5'd8, 32'hDEAD_BEEF, 1'b1, 0);
    finish_run(1);

    // Zero-length run: RELEASE straight to DONE.
    start_seq(0);
    send(5'd9, 32'h99, 1'b1, 0);
    finish_run(0);

    // Mid-run reset, with an ignored start beforehand.
    start_seq(10);
    send(5'd7, 32'h77, 1'b1, 0);
    step();
    check("run1_proc_reset", 64'(proc_reset), 64'd0);
    start      = 1'b1;
    num_cycles = 10'd0;
    step();
    start = 1'b0;
    check("start_ignored_rc", 64'(run_count), 64'd1);
    check("start_ignored_pr", 64'(proc_reset), 64'd0);
    check("start_ignored_rdy", 64'(pre.in_ready), 64'd0);
    #2 reset = 1'b0;
    #1;
    chk_reset_vals();
    #4 reset = 1'b1;
    step();
    chk_reset_vals();
    check("sb_empty_end", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_loader.md
# regfile_loader

Preload-and-run sequencer for the processor test harness: the input-side counterpart of the post-run register dump. It accepts a stream of (register index, value) pairs, writes them into the register file through the write port while holding the processor in reset, releases the processor for a programmed number of cycles, then freezes it so the register contents can be read out. It sits between the harness and the processor/regfile pair; the wrapper muxes its write-port outputs onto the regfile whenever `loader_active` is high.

## Interface
- `NUM_REGS`, 32: register count; the index width is 5 bits.
- `CYC_W`, 10: width of the run-cycle count.

- `clock`  in  1  the only clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `start`  in  1  single-cycle pulse that begins a load/run sequence; honoured only in IDLE or DONE.
- `num_cycles`  in  CYC_W  run length, latched on an accepted `start`.
- `in_valid`  in  1  a preload word is present.
- `in_ready`  out  1  the block can accept a preload word.
- `in_reg`  in  5  destination register index.
- `in_data`  in  32  value to write.
- `in_last`  in  1  marks the final preload word.
- `wr_en`  out  1  regfile write enable (registered).
- `wr_reg`  out  5  regfile write index (registered).
- `wr_data`  out  32  regfile write data (registered).
- `loader_active`  out  1  wrapper selects the loader's write port while this is high.
- `proc_reset`  out  1  active-high reset to the processor only. It never drives the regfile reset.
- `run_count`  out  CYC_W  cycles elapsed in RUN.
- `done`  out  1  the run has completed.
- `error`  out  1  sticky flag: a write to r0 was attempted.

## Operation
- States: IDLE, LOAD, RELEASE, RUN, DONE.
- IDLE
  - `proc_reset`=1, `in_ready`=0.
  - `start` latches `num_cycles`, clears `run_count` and `error`, and moves to LOAD.
- LOAD
  - `in_ready`=1, `loader_active`=1.
  - Handshake occurs on `in_valid` & `in_ready`. On the next cycle, `wr_en`=1 with `wr_reg`=`in_reg` and `wr_data`=`in_data`.
  - If `in_reg`=0: no write is issued (`wr_en` stays 0) and `error` is set.
  - A handshake with `in_last`=1 moves the block to RELEASE.
  - Repeated writes to the same index are allowed; the last write wins.
- RELEASE
  - Lasts one cycle. The final registered write commits at the edge that ends this state.
  - `loader_active`=1, `in_ready`=0.
  - Next state is RUN if the latched `num_cycles` is nonzero, otherwise DONE.
- RUN
  - `proc_reset`=0, `loader_active`=0, `wr_en`=0.
  - `run_count` increments each cycle.
  - When `run_count` = latched `num_cycles`−1, the block moves to DONE; `run_count` ends equal to `num_cycles`.
- DONE
  - `done`=1, `proc_reset`=1 (processor frozen; regfile contents preserved).
  - `start` re-enters LOAD with the same actions as from IDLE.
- `start` in LOAD, RELEASE or RUN is ignored.
- `in_valid` is ignored outside LOAD.
- The count does not wrap: the maximum run is 2^CYC_W−1 cycles.

## Timing
- Reset values (asynchronous):
  - state=IDLE, `proc_reset`=1, `in_ready`=0.
  - `wr_en`=0, `wr_reg`=0, `wr_data`=0.
  - `loader_active`=0, `run_count`=0, `done`=0, `error`=0.
- Reset asserted mid-operation forces all outputs to these values immediately, with no clock edge needed. Any pending write is dropped.
- Write latency: handshake at edge k → `wr_en` high in cycle k+1 → regfile write at edge k+1.
- `proc_reset` is low for exactly `num_cycles` consecutive cycles, starting the cycle after RELEASE.
- `done` rises on the same edge that `proc_reset` re-asserts.
- Start to first `in_ready`: 1 cycle.
- Throughput: one preload word per cycle, no bubbles.

## Test plan
- Load r1=5, then r2=−1 (`in_last`), with `num_cycles`=3:
  - `wr_en` pulses twice, with (1,5) then (2,0xFFFFFFFF).
  - `proc_reset` is low for exactly 3 cycles.
  - Then `done`=1 and `run_count`=3.
- `in_valid` with 2-cycle gaps loading r3=7, r4=9:
  - Writes are issued only on handshake cycles.
  - `loader_active` drops the cycle after RELEASE.
- Word with `in_reg`=0, `in_data`=0x1234:
  - No `wr_en` pulse for that word.
  - `error`=1 and stays high through DONE.
  - The next `start` clears it.
- Single word (`in_last`) with `num_cycles`=0:
  - Sequence is RELEASE → DONE.
  - `proc_reset` never deasserts; `run_count`=0.
- `reset` driven low for 5 ns at cycle 2 of a 10-cycle RUN:
  - All outputs return to reset values within that window.
  - `start` during RUN beforehand has no effect.
- In DONE, pulse `start` with `num_cycles`=4 and load r5=1:
  - Second run completes.
  - `run_count`=4.
